stream_packet_gen: RTL and testbench

STREAM_PACKET_GEN -- requirements
Module: stream_packet_gen

---
 rtl/stream_packet_gen.sv | 155 +++++++++++++++
 tb/tb_stream_packet_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_packet_gen.sv
// stream_packet_gen: emits one packet of `length` beats per accepted start.
// The payload is seed, seed+1, ... and wraps modulo 2^DATA_WIDTH. A fixed
// idle gap of GAP_CYCLES cycles follows every completed packet.
//
// Ports
//   sys_clk       single clock; all logic on its rising edge
//   sys_rst       synchronous active-high reset
//   start         packet request, sampled only while idle
//   length        packet length in beats (0 = request ignored), latched on start
//   seed          first payload value, latched on start
//   busy          high while sending or in the post-packet gap
//   done          one-cycle pulse after the final beat transfers
//   packets_sent  wrapping count of completed packets
//   source_valid  stream valid (registered)
//   source_last   final beat marker (registered)
//   source_data   beat payload (registered)
//   source_ready  downstream ready
module stream_packet_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8,
    parameter int GAP_CYCLES = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  length,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  packets_sent,
    output logic                  source_valid,
    output logic                  source_last,
    output logic [DATA_WIDTH-1:0] source_data,
    input  logic                  source_ready
);

    // Gap counter runs 0 .. GAP_CYCLES-1; kept at least one bit wide so the
    // design still elaborates when the gap is disabled.
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  idx_q, idx_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic [LEN_WIDTH-1:0]  idx_nxt;
    logic [LEN_WIDTH-1:0]  len_m1;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        valid_d = valid_q;
        last_d  = last_q;
        data_d  = data_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        idx_nxt = idx_q + LEN_WIDTH'(1);
        len_m1  = len_q - LEN_WIDTH'(1);

        case (state_q)
            IDLE: begin
                if (start && (length != '0)) begin
                    state_d = SEND;
                    len_d   = length;
                    idx_d   = '0;
                    valid_d = 1'b1;
                    data_d  = seed;
                    last_d  = (length == LEN_WIDTH'(1));
                end
            end
            SEND: begin
                if (valid_q && source_ready) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        data_d  = '0;
                        idx_d   = '0;
                        done_d  = 1'b1;
                        cnt_d   = cnt_q + CNT_WIDTH'(1);
                        gap_d   = '0;
                        state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
                    end else begin
                        // Precompute last for the upcoming beat so the output
                        // stays a plain register.
                        idx_d  = idx_nxt;
                        data_d = data_q + DATA_WIDTH'(1);
                        last_d = (idx_nxt == len_m1);
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign packets_sent = cnt_q;
    assign source_valid = valid_q;
    assign source_last  = last_q;
    assign source_data  = data_q;

endmodule

// File: tb/tb_stream_packet_gen.sv
// Self-checking bench for stream_packet_gen: directed scenarios plus
// randomized packets, checked against a beat-count model of the stream.
module tb_stream_packet_gen;

    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start  = 1'b0;
    logic [7:0] length = '0;
    logic [7:0] seed   = '0;
    logic       ready  = 1'b0;
    logic       busy, done, valid, last;
    logic [7:0] data;
    logic [15:0] pkts;

    logic       start_w  = 1'b0;
    logic [7:0] length_w = '0;
    logic [7:0] seed_w   = '0;
    logic       ready_w  = 1'b1;
    logic       busy_w, done_w, valid_w, last_w;
    logic [7:0] data_w;
    logic [3:0] pkts_w;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    stream_packet_gen #(
        .DATA_WIDTH(8),
        .LEN_WIDTH (8),
        .GAP_CYCLES(GAP),
        .CNT_WIDTH (16)
    ) dut (
        .sys_clk     (clk),
        .sys_rst     (rst),
        .start       (start),
        .length      (length),
        .seed        (seed),
        .busy        (busy),
        .done        (done),
        .packets_sent(pkts),
        .source_valid(valid),
        .source_last (last),
        .source_data (data),
        .source_ready(ready)
    );

    stream_packet_gen #(
        .DATA_WIDTH(8),
        .LEN_WIDTH (8),
        .GAP_CYCLES(0),
        .CNT_WIDTH (4)
    ) dut_w (
        .sys_clk     (clk),
        .sys_rst     (rst),
        .start       (start_w),
        .length      (length_w),
        .seed        (seed_w),
        .busy        (busy_w),
        .done        (done_w),
        .packets_sent(pkts_w),
        .source_valid(valid_w),
        .source_last (last_w),
        .source_data (data_w),
        .source_ready(ready_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends one packet from IDLE and follows it through the gap back to IDLE.
    // Expected beat i carries seed+i and is last only when i == len-1.
    task automatic run_pkt(input int len, input logic [7:0] sd,
                           input logic [31:0] rpat, input int rpat_len, input bit rnd);
        int i;
        int cyc;
        logic [7:0] exp_d;
        start  = 1'b1;
        length = 8'(len);
        seed   = sd;
        @(negedge clk);
        start  = 1'b0;
        length = 8'($urandom);
        seed   = 8'($urandom);
        i   = 0;
        cyc = 0;
        while (i < len && cyc < 300) begin
            exp_d = sd + 8'(i);
            chk("valid", 32'(valid), 32'(1));
            chk("data", 32'(data), 32'(exp_d));
            chk("last", 32'(last), 32'(i == len - 1));
            chk("busy", 32'(busy), 32'(1));
            chk("done_low", 32'(done), 32'(0));
            chk("pkts_send", 32'(pkts), 32'(exp_cnt % 65536));
            if (cyc < rpat_len) ready = rpat[cyc];
            else if (rnd)       ready = ($urandom_range(3) != 0);
            else                ready = 1'b1;
            // start pulses while busy must be ignored
            start  = 1'($urandom_range(1));
            length = 8'($urandom);
            if (ready) i++;
            cyc++;
            @(negedge clk);
        end
        if (i < len) begin
            chk("timeout", 32'(i), 32'(len));
            start = 1'b0;
            return;
        end
        exp_cnt++;
        chk("done_pulse", 32'(done), 32'(1));
        chk("valid_gap", 32'(valid), 32'(0));
        chk("last_gap", 32'(last), 32'(0));
        chk("data_gap", 32'(data), 32'(0));
        chk("pkts_done", 32'(pkts), 32'(exp_cnt % 65536));
        chk("busy_gap", 32'(busy), 32'(1));
        for (int g = 1; g < GAP; g++) begin
            start = 1'($urandom_range(1));
            @(negedge clk);
            chk("busy_gapn", 32'(busy), 32'(1));
            chk("valid_gapn", 32'(valid), 32'(0));
            chk("done_gapn", 32'(done), 32'(0));
        end
        start = 1'($urandom_range(1));
        @(negedge clk);
        chk("busy_idle", 32'(busy), 32'(0));
        chk("valid_idle", 32'(valid), 32'(0));
        chk("done_idle", 32'(done), 32'(0));
        chk("pkts_idle", 32'(pkts), 32'(exp_cnt % 65536));
        start = 1'b0;
        ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with start held high: must stay idle.
        rst    = 1'b1;
        start  = 1'b1;
        length = 8'd4;
        seed   = 8'h33;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(valid), 32'(0));
        chk("rst_last", 32'(last), 32'(0));
        chk("rst_data", 32'(data), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_pkts", 32'(pkts), 32'(0));
        chk("rst_pkts_w", 32'(pkts_w), 32'(0));
        chk("rst_valid_w", 32'(valid_w), 32'(0));
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'(0));

        // Zero-length start is ignored.
        start  = 1'b1;
        length = 8'd0;
        @(negedge clk);
        chk("len0_valid", 32'(valid), 32'(0));
        chk("len0_busy", 32'(busy), 32'(0));
        start = 1'b0;

        run_pkt(4, 8'hFE, 32'h0, 0, 1'b0);
        run_pkt(3, 8'h10, 32'b101001, 6, 1'b0);
        run_pkt(1, 8'h55, 32'h0, 0, 1'b0);
        chk("pkts_after_dir", 32'(pkts), 32'(3));

        // Reset after two of five beats.
        start  = 1'b1;
        length = 8'd5;
        seed   = 8'h20;
        ready  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("mid_b0", 32'(data), 32'(8'h20));
        @(negedge clk);
        chk("mid_b1", 32'(data), 32'(8'h21));
        @(negedge clk);
        chk("mid_b2", 32'(data), 32'(8'h22));
        rst = 1'b1;
        @(negedge clk);
        chk("mid_valid", 32'(valid), 32'(0));
        chk("mid_last", 32'(last), 32'(0));
        chk("mid_done", 32'(done), 32'(0));
        chk("mid_pkts", 32'(pkts), 32'(0));
        chk("mid_busy", 32'(busy), 32'(0));
        chk("mid_data", 32'(data), 32'(0));
        rst     = 1'b0;
        ready   = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        chk("mid_done2", 32'(done), 32'(0));
        run_pkt(5, 8'h20, 32'h0, 0, 1'b1);

        // Randomized packets with random backpressure.
        for (int n = 0; n < 25; n++) begin
            run_pkt(int'($urandom_range(12, 1)), 8'($urandom), 32'h0, 0, 1'b1);
        end

        // Zero-gap instance: single-beat packets back to back, counter wraps.
        for (int k = 0; k < 17; k++) begin
            start_w  = 1'b1;
            length_w = 8'd1;
            seed_w   = 8'(k * 7);
            @(negedge clk);
            start_w = 1'b0;
            chk("w_valid", 32'(valid_w), 32'(1));
            chk("w_data", 32'(data_w), 32'(8'(k * 7)));
            chk("w_last", 32'(last_w), 32'(1));
            @(negedge clk);
            chk("w_done", 32'(done_w), 32'(1));
            chk("w_valid0", 32'(valid_w), 32'(0));
            chk("w_busy0", 32'(busy_w), 32'(0));
            chk("w_pkts", 32'(pkts_w), 32'((k + 1) % 16));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
